// File: rtl/axi_stream_insert_header.sv
// Prepends an N-byte header to each AXI-Stream packet and repacks header plus
// payload MSB-first into full beats through a single registered output stage.
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // payload
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    // output stream
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    // header
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert,
    // debug: FSM state and header keep/count disagreement on a handshake
    output logic [1:0]              dbg_state_o,
    output logic                    hdr_keep_err_o
);
    // All streams use valid/ready: a transfer happens on a rising edge where
    // both are 1; a source holds its payload stable until that edge.

    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CW-1:0]           res_cnt_q, res_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;

    logic                    slot_free;
    logic                    hdr_fire;
    logic                    beat_fire;
    logic [CW-1:0]           hdr_cnt;
    logic [CW-1:0]           beat_cnt;
    logic [CW:0]             total_cnt;
    logic [DATA_WD-1:0]      beat_data;
    logic [2*DATA_WD-1:0]    merged;

    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CW-1:0] cnt);
        msb_keep = ~({DATA_BYTE_WD{1'b1}} >> cnt);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] lsb_keep(input logic [CW-1:0] cnt);
        lsb_keep = ~({DATA_BYTE_WD{1'b1}} << cnt);
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_q       <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    // output / handshake decode
    always_comb begin
        slot_free      = !out_valid_q || ready_out;
        ready_insert   = (state_q == ST_IDLE);
        ready_in       = (state_q == ST_DATA) && slot_free;
        hdr_fire       = valid_insert && ready_insert;
        beat_fire      = valid_in && ready_in;
        hdr_cnt        = (byte_insert_cnt == '0) ? FULL_CNT : {1'b0, byte_insert_cnt};
        hdr_keep_err_o = hdr_fire && (keep_insert != lsb_keep(hdr_cnt));
        dbg_state_o    = state_q;
        valid_out      = out_valid_q;
        data_out       = out_data_q;
        keep_out       = out_keep_q;
        last_out       = out_last_q;
    end

    // next state and datapath
    always_comb begin
        beat_cnt  = '0;
        beat_data = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            beat_cnt              = beat_cnt + CW'(keep_in[i]);
            beat_data[8*i +: 8]   = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
        end
        total_cnt = {1'b0, res_cnt_q} + {1'b0, beat_cnt};
        // Residue sits MSB-aligned; the beat slides in right behind it.
        merged = {res_q, {DATA_WD{1'b0}}} | ({beat_data, {DATA_WD{1'b0}}} >> (8 * res_cnt_q));

        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = slot_free ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    res_d     = data_insert << (8 * (DATA_BYTE_WD - hdr_cnt));
                    res_cnt_d = hdr_cnt;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = merged[2*DATA_WD-1:DATA_WD];
                    if (last_in && (total_cnt > {1'b0, FULL_CNT})) begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_d      = merged[DATA_WD-1:0];
                        res_cnt_d  = CW'(total_cnt - {1'b0, FULL_CNT});
                        state_d    = ST_TAIL;
                    end else if (last_in) begin
                        out_keep_d = msb_keep(CW'(total_cnt));
                        out_last_d = 1'b1;
                        res_d      = '0;
                        res_cnt_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        res_d      = merged[DATA_WD-1:0];
                    end
                end
            end
            ST_TAIL: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_q;
                    out_keep_d  = msb_keep(res_cnt_q);
                    out_last_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header: hand-computed beats for header
// insertion, tail beats, back-pressure, full-width header and mid-packet reset.
module tb_axi_stream_insert_header;
    localparam int DATA_WD      = 32;
    localparam int DATA_BYTE_WD = 4;
    localparam int BYTE_CNT_WD  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;
    logic [1:0]              dbg_state_o;
    logic                    hdr_keep_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    axi_stream_insert_header #(
        .DATA_WD(DATA_WD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_insert   (valid_insert),
        .data_insert    (data_insert),
        .keep_insert    (keep_insert),
        .byte_insert_cnt(byte_insert_cnt),
        .ready_insert   (ready_insert),
        .dbg_state_o    (dbg_state_o),
        .hdr_keep_err_o (hdr_keep_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                              input logic l);
        check({tag, ".valid"}, 32'(valid_out), 32'd1);
        check({tag, ".data"},  data_out, d);
        check({tag, ".keep"},  32'(keep_out), 32'(k));
        check({tag, ".last"},  32'(last_out), 32'(l));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_hdr(input logic v, input logic [31:0] d, input logic [3:0] k,
                           input logic [1:0] c);
        valid_insert    = v;
        data_insert     = d;
        keep_insert     = k;
        byte_insert_cnt = c;
    endtask

    task automatic set_beat(input logic v, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
        valid_in = v;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
    endtask

    initial begin
        rst_n     = 1'b1;
        ready_out = 1'b1;
        set_hdr(1'b0, '0, '0, '0);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        check("rst.valid_out", 32'(valid_out), 32'd0);
        check("rst.last_out",  32'(last_out),  32'd0);
        check("rst.data_out",  data_out,       32'd0);
        check("rst.keep_out",  32'(keep_out),  32'd0);
        check("rst.ready_in",  32'(ready_in),  32'd0);
        check("rst.state",     32'(dbg_state_o), 32'd0);
        rst_n = 1'b0;
        tick();
        check("rst.ready_insert", 32'(ready_insert), 32'd1);

        // payload with no header waits
        set_beat(1'b1, 32'h01020304, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nohdr.ready_in",  32'(ready_in),  32'd0);
            check("nohdr.valid_out", 32'(valid_out), 32'd0);
        end

        // header N=3, two-beat payload with tail
        set_hdr(1'b1, 32'hAA55AA55, 4'b0111, 2'd3);
        settle();
        check("p1.hdr_keep_err", 32'(hdr_keep_err_o), 32'd0);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        settle();
        check("p1.ready_in", 32'(ready_in), 32'd1);
        check("p1.ready_insert", 32'(ready_insert), 32'd0);
        check("p1.valid_out0", 32'(valid_out), 32'd0);
        tick();
        check_beat("p1.b0", 32'h55AA5501, 4'b1111, 1'b0);
        set_beat(1'b1, 32'h05060708, 4'b1100, 1'b1);
        tick();
        check_beat("p1.b1", 32'h02030405, 4'b1111, 1'b0);
        check("p1.tail_ready_in", 32'(ready_in), 32'd0);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        check_beat("p1.b2", 32'h06000000, 4'b1000, 1'b1);
        check("p1.ready_insert_end", 32'(ready_insert), 32'd1);
        tick();
        check("p1.idle_valid_out", 32'(valid_out), 32'd0);

        // header N=1, single payload beat spills into a tail
        set_hdr(1'b1, 32'hAA55AA55, 4'b0001, 2'd1);
        set_beat(1'b1, 32'h11223344, 4'b1111, 1'b1);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        tick();
        check_beat("p2.b0", 32'h55112233, 4'b1111, 1'b0);
        check("p2.tail_ready_in", 32'(ready_in), 32'd0);
        check("p2.tail_state", 32'(dbg_state_o), 32'd2);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        check_beat("p2.b1", 32'h44000000, 4'b1000, 1'b1);

        // back-pressure for 4 cycles mid-packet
        set_hdr(1'b1, 32'h0000BEEF, 4'b0011, 2'd2);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        set_beat(1'b1, 32'h10111213, 4'b1111, 1'b0);
        tick();
        check_beat("p3.b0", 32'hBEEF1011, 4'b1111, 1'b0);
        ready_out = 1'b0;
        set_beat(1'b1, 32'h20212223, 4'b1111, 1'b0);
        settle();
        check("p3.stall_ready_in0", 32'(ready_in), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_beat("p3.hold", 32'hBEEF1011, 4'b1111, 1'b0);
            check("p3.stall_ready_in", 32'(ready_in), 32'd0);
        end
        ready_out = 1'b1;
        settle();
        check("p3.release_ready_in", 32'(ready_in), 32'd1);
        tick();
        check_beat("p3.b1", 32'h12132021, 4'b1111, 1'b0);
        set_beat(1'b1, 32'h30313233, 4'b1110, 1'b1);
        tick();
        check_beat("p3.b2", 32'h22233031, 4'b1111, 1'b0);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        check_beat("p3.b3", 32'h32000000, 4'b1000, 1'b1);
        tick();
        check("p3.idle_valid_out", 32'(valid_out), 32'd0);

        // full-width header (count 0): header beat then payload unchanged
        set_hdr(1'b1, 32'h11223344, 4'b1111, 2'd0);
        set_beat(1'b1, 32'hA0A1A2A3, 4'b1111, 1'b1);
        settle();
        check("p4.hdr_keep_err", 32'(hdr_keep_err_o), 32'd0);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        tick();
        check_beat("p4.b0", 32'h11223344, 4'b1111, 1'b0);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        check_beat("p4.b1", 32'hA0A1A2A3, 4'b1111, 1'b1);

        // header N=2 + last beat of 2 bytes fills exactly one beat
        set_hdr(1'b1, 32'h0000CAFE, 4'b0011, 2'd2);
        set_beat(1'b1, 32'h5A5BFFFF, 4'b1100, 1'b1);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        tick();
        check_beat("p5.b0", 32'hCAFE5A5B, 4'b1111, 1'b1);
        check("p5.state", 32'(dbg_state_o), 32'd0);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();

        // reset in DATA after two output beats
        set_hdr(1'b1, 32'hAA55AA55, 4'b0111, 2'd3);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        set_beat(1'b1, 32'h01020304, 4'b1111, 1'b0);
        tick();
        check_beat("p6.b0", 32'h55AA5501, 4'b1111, 1'b0);
        set_beat(1'b1, 32'h05060708, 4'b1111, 1'b0);
        tick();
        check_beat("p6.b1", 32'h02030405, 4'b1111, 1'b0);
        set_beat(1'b0, 32'h090A0B0C, 4'b1111, 1'b0);
        rst_n = 1'b1;
        tick();
        check("p6.rst_valid_out", 32'(valid_out), 32'd0);
        check("p6.rst_ready_insert", 32'(ready_insert), 32'd1);
        check("p6.rst_ready_in", 32'(ready_in), 32'd0);
        rst_n = 1'b0;
        tick();
        check("p6.after_valid_out", 32'(valid_out), 32'd0);
        set_hdr(1'b1, 32'h00000C0D, 4'b0011, 2'd2);
        set_beat(1'b1, 32'hE0E1E2E3, 4'b1000, 1'b1);
        tick();
        set_hdr(1'b0, '0, '0, '0);
        check("p7.valid_out_hdr", 32'(valid_out), 32'd0);
        tick();
        check_beat("p7.b0", 32'h0C0DE000, 4'b1110, 1'b1);
        set_beat(1'b0, '0, '0, 1'b0);
        tick();
        check("p7.idle_valid_out", 32'(valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_stream_insert_header.md
AXI_STREAM_INSERT_HEADER -- requirements
Module: axi_stream_insert_header

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 32, meaning stream data width in bits.
REQ-002 The block SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, meaning the number of byte lanes.
REQ-003 The block SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), meaning the header byte-count width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous reset, asserted when 1.
REQ-007 Port valid_in, input, 1 bit: payload beat valid.
REQ-008 Port data_in, input, DATA_WD: payload beat; byte 0 is in bits [DATA_WD-1:DATA_WD-8] (MSB-first).
REQ-009 Port keep_in, input, DATA_BYTE_WD: payload byte enables; all ones except on the last beat, where they are contiguous from the MSB lane and nonzero.
REQ-010 Port last_in, input, 1 bit: final payload beat of the packet.
REQ-011 Port ready_in, output, 1 bit: payload beat accepted when valid_in and ready_in are both 1.
REQ-012 Port valid_out, output, 1 bit: output beat valid.
REQ-013 Port data_out, output, DATA_WD: output beat; unused byte lanes are 0.
REQ-014 Port keep_out, output, DATA_BYTE_WD: output byte enables, contiguous from the MSB lane.
REQ-015 Port last_out, output, 1 bit: final output beat of the packet.
REQ-016 Port ready_out, input, 1 bit: downstream ready.
REQ-017 Port valid_insert, input, 1 bit: header valid.
REQ-018 Port data_insert, input, DATA_WD: header word; valid bytes are LSB-aligned.
REQ-019 Port keep_insert, input, DATA_BYTE_WD: header byte enables, contiguous from the LSB lane; used for consistency checking only.
REQ-020 Port byte_insert_cnt, input, BYTE_CNT_WD: number of valid header bytes N; the value 0 means N = DATA_BYTE_WD.
REQ-021 Port ready_insert, output, 1 bit: header accepted when valid_insert and ready_insert are both 1.

Function
REQ-022 The block SHALL output each packet as the N header bytes, then all enabled payload bytes in order, repacked MSB-first into full beats.
REQ-023 The number of output beats SHALL be ceil((N + payload bytes) / DATA_BYTE_WD).
REQ-024 On the last output beat, keep_out SHALL mark exactly the remaining bytes and last_out SHALL be 1; on every other beat keep_out SHALL be all ones.
REQ-025 The control FSM SHALL have states IDLE, DATA and TAIL.
REQ-026 In IDLE: ready_insert = 1 and ready_in = 0; a header handshake latches the N header bytes into a residue buffer and moves to DATA.
REQ-027 In DATA: ready_in = 1 when the output register is empty or ready_out = 1; each accepted beat combines the residue with its leading bytes into one output beat, and the rest becomes the new residue.
REQ-028 On an accepted last_in beat: if the residue plus last-beat bytes exceed DATA_BYTE_WD, move to TAIL; otherwise emit the last beat and return to IDLE.
REQ-029 In TAIL: ready_in = 0; the final partial beat is emitted, then the FSM returns to IDLE.
REQ-030 ready_insert SHALL be 0 in DATA and TAIL; headers and payload arriving out of turn wait under back-pressure.
REQ-031 The output SHALL be registered: a beat appears on valid_out the cycle after the accepted input beat that completes it.
REQ-032 Sustained throughput SHALL be one beat per cycle.
REQ-033 While valid_out = 1 and ready_out = 0, data_out, keep_out and last_out SHALL hold stable and no input SHALL be accepted.
REQ-034 When N = DATA_BYTE_WD, the header SHALL be emitted as a whole beat and the payload passed through unchanged, one beat later.

Reset
REQ-035 While rst_n = 1 at a clock edge: the FSM goes to IDLE, the residue is cleared, and valid_out, last_out, data_out, keep_out and ready_in are 0; ready_insert is 1 from the first cycle after reset.
REQ-036 Reset mid-packet SHALL discard the packet; no partial beat SHALL be emitted afterwards.

Verification
REQ-037 Header AA55AA55, N = 3 (keep_insert 0111); payload 01020304 (1111), then 05060708 with keep_in 1100 and last_in = 1 -> outputs 55AA5501/1111, 02030405/1111, 06000000/1000 with last_out = 1.
REQ-038 Header AA55AA55, N = 1 (keep_insert 0001); payload 11223344 (1111, last) -> outputs 55112233/1111, then 44000000/1000 with last_out = 1; ready_in = 0 during the tail cycle.
REQ-039 ready_out = 0 for 4 cycles mid-packet -> valid_out stays 1 with data_out held, ready_in = 0, and no bytes are lost or duplicated after release.
REQ-040 valid_in = 1 with no header -> ready_in stays 0 and valid_out stays 0 until the header handshake.
REQ-041 Header 11223344, byte_insert_cnt = 0 (keep_insert 1111); payload A0A1A2A3 (last) -> outputs 11223344/1111, then A0A1A2A3/1111 with last_out = 1.
REQ-042 Reset asserted in DATA after two output beats -> next cycle valid_out = 0 and ready_insert = 1; the following packet is output correctly.
